// File: rtl/dlx_pkg.sv
// DLX ID/EX shared definitions: ALU op codes, opcode/func encodings and the
// decoded control bundle passed from alu_ctrl_decode to the ID/EX registers.
package dlx_pkg;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00011;
    localparam logic [4:0] ALU_XOR = 5'b00100;
    localparam logic [4:0] ALU_SLL = 5'b00101;
    localparam logic [4:0] ALU_SRL = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b01000;
    localparam logic [4:0] ALU_SGE = 5'b01001;
    localparam logic [4:0] ALU_SGT = 5'b01010;
    localparam logic [4:0] ALU_LHI = 5'b01100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLL = 6'h04;
    localparam logic [5:0] FN_SRL = 6'h06;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SGE = 6'h2D;
    localparam logic [5:0] FN_SGT = 6'h2B;

    // rd_sel=1 picks instr[15:11] (R-type), 0 picks instr[20:16] (I-type)
    typedef struct packed {
        logic [4:0] alu_op;
        logic       use_imm;
        logic       imm_zext;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       rd_sel;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/func decode into the ALU op and EX/MEM control bundle.
// Unknown encodings decode to an add with no writeback and the illegal flag set.
module alu_ctrl_decode
    import dlx_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o          = '0;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.regwrite = 1'b1;
        if (opcode_i == OP_RTYPE) begin
            ctrl_o.rd_sel = 1'b1;
            case (func_i)
                FN_AND:  ctrl_o.alu_op = ALU_AND;
                FN_OR:   ctrl_o.alu_op = ALU_OR;
                FN_ADD:  ctrl_o.alu_op = ALU_ADD;
                FN_SUB:  ctrl_o.alu_op = ALU_SUB;
                FN_XOR:  ctrl_o.alu_op = ALU_XOR;
                FN_SLL:  ctrl_o.alu_op = ALU_SLL;
                FN_SRL:  ctrl_o.alu_op = ALU_SRL;
                FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                FN_SGE:  ctrl_o.alu_op = ALU_SGE;
                FN_SGT:  ctrl_o.alu_op = ALU_SGT;
                default: begin
                    ctrl_o.illegal  = 1'b1;
                    ctrl_o.regwrite = 1'b0;
                end
            endcase
        end else begin
            ctrl_o.use_imm = 1'b1;
            case (opcode_i)
                OP_ADDI: ctrl_o.alu_op = ALU_ADD;
                OP_SUBI: ctrl_o.alu_op = ALU_SUB;
                OP_ANDI: begin
                    ctrl_o.alu_op   = ALU_AND;
                    ctrl_o.imm_zext = 1'b1;
                end
                OP_ORI: begin
                    ctrl_o.alu_op   = ALU_OR;
                    ctrl_o.imm_zext = 1'b1;
                end
                OP_XORI: begin
                    ctrl_o.alu_op   = ALU_XOR;
                    ctrl_o.imm_zext = 1'b1;
                end
                OP_LHI: begin
                    ctrl_o.alu_op   = ALU_LHI;
                    ctrl_o.imm_zext = 1'b1;
                end
                OP_SLLI: ctrl_o.alu_op = ALU_SLL;
                OP_SRLI: ctrl_o.alu_op = ALU_SRL;
                OP_SLTI: ctrl_o.alu_op = ALU_SLT;
                OP_LW:   ctrl_o.memread = 1'b1;
                OP_SW: begin
                    ctrl_o.memwrite = 1'b1;
                    ctrl_o.regwrite = 1'b0;
                end
                default: begin
                    ctrl_o.illegal  = 1'b1;
                    ctrl_o.regwrite = 1'b0;
                    ctrl_o.use_imm  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/idex_operand_stage.sv
// DLX ID/EX pipeline register with operand forwarding in front of the ALU.
// Operands are forwarded combinationally from the latched register indices.
module idex_operand_stage
    import dlx_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [5:0]         id_opcode_i,
    input  logic [5:0]         id_func_i,
    input  logic [REGBITS-1:0] id_rs1_i,
    input  logic [REGBITS-1:0] id_rs2_i,
    input  logic [REGBITS-1:0] id_rd_i,
    input  logic [15:0]        id_imm16_i,
    input  logic [XLEN-1:0]    id_rs1_val_i,
    input  logic [XLEN-1:0]    id_rs2_val_i,
    input  logic [REGBITS-1:0] exm_rd_i,
    input  logic               exm_we_i,
    input  logic [XLEN-1:0]    exm_result_i,
    input  logic [REGBITS-1:0] wb_rd_i,
    input  logic               wb_we_i,
    input  logic [XLEN-1:0]    wb_result_i,
    output logic [XLEN-1:0]    alu_a_o,
    output logic [XLEN-1:0]    alu_b_o,
    output logic [4:0]         alu_op_o,
    output logic               ex_valid_o,
    output logic [REGBITS-1:0] ex_rd_o,
    output logic               ex_regwrite_o,
    output logic               ex_memread_o,
    output logic               ex_memwrite_o,
    output logic [XLEN-1:0]    ex_store_data_o,
    output logic               ex_illegal_o
);

    ctrl_t              dec;
    logic [XLEN-1:0]    imm_ext;
    logic [XLEN-1:0]    fwd_a, fwd_b;

    logic               valid_q, valid_d;
    logic [REGBITS-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]    rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
    logic               use_imm_q, use_imm_d;
    logic [4:0]         alu_op_q, alu_op_d;
    logic               regwrite_q, regwrite_d, memread_q, memread_d;
    logic               memwrite_q, memwrite_d, illegal_q, illegal_d;

    alu_ctrl_decode u_dec (
        .opcode_i (id_opcode_i),
        .func_i   (id_func_i),
        .ctrl_o   (dec)
    );

    function automatic logic hit(input logic we, input logic [REGBITS-1:0] prod,
                                 input logic [REGBITS-1:0] src);
        return we && (prod == src) && (src != '0);
    endfunction

    assign imm_ext = dec.imm_zext ? {{(XLEN-16){1'b0}}, id_imm16_i}
                                  : {{(XLEN-16){id_imm16_i[15]}}, id_imm16_i};

    assign fwd_a = hit(exm_we_i, exm_rd_i, rs1_q) ? exm_result_i :
                   hit(wb_we_i,  wb_rd_i,  rs1_q) ? wb_result_i  : rs1_val_q;
    assign fwd_b = hit(exm_we_i, exm_rd_i, rs2_q) ? exm_result_i :
                   hit(wb_we_i,  wb_rd_i,  rs2_q) ? wb_result_i  : rs2_val_q;

    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        imm_d      = imm_q;
        use_imm_d  = use_imm_q;
        alu_op_d   = alu_op_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        illegal_d  = illegal_q;
        if (flush_i || (!stall_i && !id_valid_i)) begin
            valid_d    = 1'b0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            rs1_val_d  = '0;
            rs2_val_d  = '0;
            imm_d      = '0;
            use_imm_d  = 1'b0;
            alu_op_d   = ALU_ADD;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            illegal_d  = 1'b0;
        end else if (!stall_i) begin
            valid_d    = 1'b1;
            rs1_d      = id_rs1_i;
            rs2_d      = id_rs2_i;
            rd_d       = dec.rd_sel ? id_rd_i : id_rs2_i;
            rs1_val_d  = id_rs1_val_i;
            rs2_val_d  = id_rs2_val_i;
            imm_d      = dec.use_imm ? imm_ext : '0;
            use_imm_d  = dec.use_imm;
            alu_op_d   = dec.alu_op;
            regwrite_d = dec.regwrite;
            memread_d  = dec.memread;
            memwrite_d = dec.memwrite;
            illegal_d  = dec.illegal;
        end else begin
            // The retiring writeback will be gone when the stall releases, so bank it now
            if (hit(wb_we_i, wb_rd_i, rs1_q)) rs1_val_d = wb_result_i;
            if (hit(wb_we_i, wb_rd_i, rs2_q)) rs2_val_d = wb_result_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            alu_op_q   <= ALU_ADD;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_val_q  <= rs1_val_d;
            rs2_val_q  <= rs2_val_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            alu_op_q   <= alu_op_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_a_o         = fwd_a;
    assign alu_b_o         = use_imm_q ? imm_q : fwd_b;
    assign ex_store_data_o = fwd_b;
    assign alu_op_o        = alu_op_q;
    assign ex_valid_o      = valid_q;
    assign ex_rd_o         = rd_q;
    assign ex_regwrite_o   = regwrite_q;
    assign ex_memread_o    = memread_q;
    assign ex_memwrite_o   = memwrite_q;
    assign ex_illegal_o    = illegal_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Bench for idex_operand_stage: decode/forwarding vector table through a
// one-deep scoreboard, then reset, stall-capture and flush sequences.
module tb_idex_operand_stage;

    typedef struct {
        logic        valid;
        logic [31:0] a, b, st;
        logic [4:0]  op, rd;
        logic        rw, mr, mw, ill;
        bit          chk_ops;
    } exp_t;

    typedef struct {
        logic        id_valid;
        logic [5:0]  opcode, func;
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] imm16;
        logic [31:0] rs1_val, rs2_val;
        logic [4:0]  exm_rd;
        logic        exm_we;
        logic [31:0] exm_result;
        logic [4:0]  wb_rd;
        logic        wb_we;
        logic [31:0] wb_result;
        exp_t        e;
    } vector_t;

    localparam int NV = 17;

    logic        clk = 1'b0, reset, stall, flush, id_valid;
    logic [5:0]  id_opcode, id_func;
    logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
    logic [15:0] id_imm16;
    logic [31:0] id_rs1_val, id_rs2_val, exm_result, wb_result;
    logic        exm_we, wb_we;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_op, ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_illegal;

    int          n_cmp = 0;
    int          n_err = 0;
    vector_t     vecs[NV];
    exp_t        sb_q[$];
    int          sb_idx[$];

    always #5 clk = ~clk;

    idex_operand_stage dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .stall_i         (stall),
        .flush_i         (flush),
        .id_valid_i      (id_valid),
        .id_opcode_i     (id_opcode),
        .id_func_i       (id_func),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_rd_i         (id_rd),
        .id_imm16_i      (id_imm16),
        .id_rs1_val_i    (id_rs1_val),
        .id_rs2_val_i    (id_rs2_val),
        .exm_rd_i        (exm_rd),
        .exm_we_i        (exm_we),
        .exm_result_i    (exm_result),
        .wb_rd_i         (wb_rd),
        .wb_we_i         (wb_we),
        .wb_result_i     (wb_result),
        .alu_a_o         (alu_a),
        .alu_b_o         (alu_b),
        .alu_op_o        (alu_op),
        .ex_valid_o      (ex_valid),
        .ex_rd_o         (ex_rd),
        .ex_regwrite_o   (ex_regwrite),
        .ex_memread_o    (ex_memread),
        .ex_memwrite_o   (ex_memwrite),
        .ex_store_data_o (ex_store_data),
        .ex_illegal_o    (ex_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_exp(input exp_t e, input int idx);
        check($sformatf("v%0d.valid", idx), {31'd0, ex_valid}, {31'd0, e.valid});
        check($sformatf("v%0d.op", idx), {27'd0, alu_op}, {27'd0, e.op});
        check($sformatf("v%0d.regwrite", idx), {31'd0, ex_regwrite}, {31'd0, e.rw});
        check($sformatf("v%0d.memread", idx), {31'd0, ex_memread}, {31'd0, e.mr});
        check($sformatf("v%0d.memwrite", idx), {31'd0, ex_memwrite}, {31'd0, e.mw});
        check($sformatf("v%0d.illegal", idx), {31'd0, ex_illegal}, {31'd0, e.ill});
        if (e.chk_ops) begin
            check($sformatf("v%0d.a", idx), alu_a, e.a);
            check($sformatf("v%0d.b", idx), alu_b, e.b);
            check($sformatf("v%0d.store", idx), ex_store_data, e.st);
            check($sformatf("v%0d.rd", idx), {27'd0, ex_rd}, {27'd0, e.rd});
        end
    endtask

    task automatic drive_vec(input vector_t v);
        id_valid   = v.id_valid;
        id_opcode  = v.opcode;
        id_func    = v.func;
        id_rs1     = v.rs1;
        id_rs2     = v.rs2;
        id_rd      = v.rd;
        id_imm16   = v.imm16;
        id_rs1_val = v.rs1_val;
        id_rs2_val = v.rs2_val;
        exm_rd     = v.exm_rd;
        exm_we     = v.exm_we;
        exm_result = v.exm_result;
        wb_rd      = v.wb_rd;
        wb_we      = v.wb_we;
        wb_result  = v.wb_result;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_opcode = '0; id_func = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_imm16 = '0; id_rs1_val = '0; id_rs2_val = '0;
        exm_rd = '0; exm_we = 1'b0; exm_result = '0; wb_rd = '0; wb_we = 1'b0; wb_result = '0;

        vecs[0]  = '{1'b1, 6'h00, 6'h22, 5'd1, 5'd2, 5'd3, 16'h0000, 32'd5, 32'd3, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd5, 32'd3, 32'd3, 5'h03, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[1]  = '{1'b1, 6'h08, 6'h00, 5'd4, 5'd7, 5'd0, 16'hFFFF, 32'd10, 32'h22, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd10, 32'hFFFFFFFF, 32'h22, 5'h02, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[2]  = '{1'b1, 6'h0C, 6'h00, 5'd4, 5'd6, 5'd0, 16'hFFFF, 32'd1, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd1, 32'h0000FFFF, 32'h0, 5'h00, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[3]  = '{1'b1, 6'h0F, 6'h00, 5'd0, 5'd5, 5'd0, 16'h1234, 32'd0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd0, 32'h00001234, 32'h0, 5'h0C, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[4]  = '{1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd9, 16'h0000, 32'd7, 32'd8, 5'd1, 1'b1, 32'hAA, 5'd1, 1'b1, 32'hBB, '{1'b1, 32'hAA, 32'd8, 32'd8, 5'h02, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[5]  = '{1'b1, 6'h00, 6'h20, 5'd0, 5'd2, 5'd9, 16'h0000, 32'h11, 32'd8, 5'd0, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hBB, '{1'b1, 32'h11, 32'd8, 32'd8, 5'h02, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{1'b1, 6'h00, 6'h25, 5'd3, 5'd4, 5'd10, 16'h0000, 32'd1, 32'd2, 5'd0, 1'b0, 32'h0, 5'd4, 1'b1, 32'hCC, '{1'b1, 32'd1, 32'hCC, 32'hCC, 5'h01, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[7]  = '{1'b1, 6'h23, 6'h00, 5'd5, 5'd8, 5'd0, 16'hFFFC, 32'h64, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'h64, 32'hFFFFFFFC, 32'h0, 5'h02, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[8]  = '{1'b1, 6'h2B, 6'h00, 5'd5, 5'd8, 5'd0, 16'h0004, 32'h64, 32'h77, 5'd8, 1'b1, 32'h99, 5'd0, 1'b0, 32'h0, '{1'b1, 32'h64, 32'h4, 32'h99, 5'h02, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[9]  = '{1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 16'h0000, 32'd3, 32'd4, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd0, 32'd0, 32'd0, 5'h02, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[10] = '{1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 16'h0000, 32'd3, 32'd4, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd0, 32'd0, 32'd0, 5'h02, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[11] = '{1'b0, 6'h00, 6'h22, 5'd1, 5'd2, 5'd3, 16'h0000, 32'd5, 32'd3, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b0, 32'd0, 32'd0, 32'd0, 5'h02, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[12] = '{1'b1, 6'h0E, 6'h00, 5'd1, 5'd2, 5'd0, 16'h8001, 32'd3, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd3, 32'h00008001, 32'h0, 5'h04, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[13] = '{1'b1, 6'h1A, 6'h00, 5'd1, 5'd3, 5'd0, 16'h8000, 32'd3, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd3, 32'hFFFF8000, 32'h0, 5'h08, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[14] = '{1'b1, 6'h00, 6'h2B, 5'd1, 5'd2, 5'd4, 16'h0000, 32'd3, 32'd4, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd3, 32'd4, 32'd4, 5'h0A, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[15] = '{1'b1, 6'h16, 6'h00, 5'd1, 5'd5, 5'd0, 16'h0003, 32'd3, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd3, 32'd3, 32'h0, 5'h06, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[16] = '{1'b1, 6'h00, 6'h2D, 5'd1, 5'd2, 5'd6, 16'h0000, 32'd1, 32'd2, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, '{1'b1, 32'd1, 32'd2, 32'd2, 5'h09, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};

        repeat (2) @(negedge clk);
        check("reset.valid", {31'd0, ex_valid}, 32'd0);
        check("reset.op", {27'd0, alu_op}, 32'h2);
        check("reset.a", alu_a, 32'h0);
        check("reset.b", alu_b, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (sb_q.size() > 0) compare_exp(sb_q.pop_front(), sb_idx.pop_front());
            drive_vec(vecs[i]);
            sb_q.push_back(vecs[i].e);
            sb_idx.push_back(i);
        end
        @(negedge clk);
        if (sb_q.size() > 0) compare_exp(sb_q.pop_front(), sb_idx.pop_front());

        // asynchronous reset in the middle of a cycle
        drive_vec(vecs[0]);
        @(negedge clk);
        check("prerst.valid", {31'd0, ex_valid}, 32'd1);
        check("prerst.a", alu_a, 32'd5);
        #2 reset = 1'b1;
        #1;
        check("midrst.valid", {31'd0, ex_valid}, 32'd0);
        check("midrst.op", {27'd0, alu_op}, 32'h2);
        check("midrst.a", alu_a, 32'h0);
        check("midrst.b", alu_b, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // stall for three edges with a writeback to rs2 retiring mid-stall
        drive_vec(vecs[0]);
        @(negedge clk);
        stall = 1'b1;
        drive_vec(vecs[1]);
        @(negedge clk);
        check("stall.a", alu_a, 32'd5);
        check("stall.b", alu_b, 32'd3);
        check("stall.op", {27'd0, alu_op}, 32'h3);
        check("stall.rd", {27'd0, ex_rd}, 32'd3);
        wb_rd = 5'd2; wb_we = 1'b1; wb_result = 32'h55;
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        check("stallwb.b", alu_b, 32'h55);
        check("stallwb.store", ex_store_data, 32'h55);
        check("stallwb.a", alu_a, 32'd5);
        @(negedge clk);
        check("stallend.b", alu_b, 32'h55);
        check("stallend.valid", {31'd0, ex_valid}, 32'd1);
        stall = 1'b0;
        @(negedge clk);
        check("release.op", {27'd0, alu_op}, 32'h2);
        check("release.a", alu_a, 32'd10);
        check("release.b", alu_b, 32'hFFFFFFFF);
        check("release.rd", {27'd0, ex_rd}, 32'd7);

        // flush wins over stall
        stall = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush.valid", {31'd0, ex_valid}, 32'd0);
        check("flush.op", {27'd0, alu_op}, 32'h2);
        check("flush.regwrite", {31'd0, ex_regwrite}, 32'd0);
        check("flush.a", alu_a, 32'h0);
        check("flush.b", alu_b, 32'h0);
        stall = 1'b0; flush = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
